// File: rtl/data_sram_axi_resp_pkg.sv
// Shared types and AXI constants for the data-SRAM-to-AXI responder.
package data_sram_axi_resp_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdAddr,
      StRdData,
      StWrReq,
      StWrResp,
      StDone
   } state_e;

   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

   // The bus always moves whole words; byte lanes are chosen by the strobes.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hffff_fffc;
   endfunction

endpackage

// File: rtl/data_sram_axi_resp_aw_w_issue.sv
// Drives AWVALID/WVALID for one single-beat write and tracks which
// handshakes have completed, so the two channels may finish in any order.
module data_sram_axi_resp_aw_w_issue (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic awready,
   input  logic wready,
   output logic awvalid,
   output logic wvalid,
   output logic done
);

   logic awvalid_q, awvalid_d;
   logic wvalid_q, wvalid_d;
   logic aw_done_q, aw_done_d;
   logic w_done_q, w_done_d;
   logic aw_hs, w_hs;

   assign aw_hs = awvalid_q & awready;
   assign w_hs  = wvalid_q & wready;

   // Both channels finished, counting handshakes that complete this cycle.
   assign done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

   assign awvalid = awvalid_q;
   assign wvalid  = wvalid_q;

   // Next-state: raise both valids on start, drop each on its own handshake.
   always_comb begin
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      if (start) begin
         awvalid_d = 1'b1;
         wvalid_d  = 1'b1;
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end else begin
         if (aw_hs) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
         end
         if (w_hs) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
         end
      end
   end

   // Channel state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

endmodule

// File: rtl/data_sram_axi_resp.sv
// Turns the core's data-SRAM request into a single-beat AXI transaction and
// stalls the pipeline while it is outstanding.
// Build option: DATA_SRAM_POSTED_WR_EN makes stores complete after AW/W and
// waits for B in the background; the next request waits for that B.
module data_sram_axi_resp
   import data_sram_axi_resp_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'd1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   output logic        wlast,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   state_e      state_q, state_d;
   logic        arvalid_q, arvalid_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  wen_q, wen_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        wr_start;
   logic        wr_done;
   logic        issue_ok;

   data_sram_axi_resp_aw_w_issue u_aw_w_issue (
      .clk     (clk),
      .resetn  (resetn),
      .start   (wr_start),
      .awready (awready),
      .wready  (wready),
      .awvalid (awvalid),
      .wvalid  (wvalid),
      .done    (wr_done)
   );

`ifdef DATA_SRAM_POSTED_WR_EN
   logic b_pending_q, b_pending_d;

   assign issue_ok = !b_pending_q;
   assign bready   = b_pending_q;

   // Track the one store whose B response is still in flight.
   always_comb begin
      b_pending_d = b_pending_q;
      if (state_q == StWrReq && wr_done) begin
         b_pending_d = 1'b1;
      end else if (bvalid) begin
         b_pending_d = 1'b0;
      end
   end

   // Posted-write flag register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         b_pending_q <= 1'b0;
      end else begin
         b_pending_q <= b_pending_d;
      end
   end
`else
   assign issue_ok = 1'b1;
   assign bready   = (state_q == StWrResp);
`endif

   assign stallreq = ((state_q != StIdle) && (state_q != StDone)) ||
                     ((state_q == StIdle) && data_sram_en);

   assign data_sram_rdata = rdata_q;
   assign rready          = (state_q == StRdData);

   assign arid    = AXI_ID;
   assign araddr  = addr_q;
   assign arlen   = AXI_LEN_SINGLE;
   assign arsize  = AXI_SIZE_WORD;
   assign arburst = AXI_BURST_INCR;
   assign arvalid = arvalid_q;

   assign awid    = AXI_ID;
   assign awaddr  = addr_q;
   assign awlen   = AXI_LEN_SINGLE;
   assign awsize  = AXI_SIZE_WORD;
   assign awburst = AXI_BURST_INCR;
   assign wdata   = wdata_q;
   assign wstrb   = wen_q;
   assign wlast   = 1'b1;

   // Next-state and datapath: latch the request in IDLE, walk the channels.
   always_comb begin
      state_d   = state_q;
      arvalid_d = arvalid_q;
      addr_d    = addr_q;
      wen_d     = wen_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      wr_start  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (data_sram_en && issue_ok) begin
               addr_d  = word_align(data_sram_addr);
               wen_d   = data_sram_wen;
               wdata_d = data_sram_wdata;
               if (data_sram_wen == 4'b0000) begin
                  state_d   = StRdAddr;
                  arvalid_d = 1'b1;
               end else begin
                  state_d  = StWrReq;
                  wr_start = 1'b1;
               end
            end
         end
         StRdAddr: begin
            if (arready) begin
               arvalid_d = 1'b0;
               state_d   = StRdData;
            end
         end
         StRdData: begin
            if (rvalid) begin
               rdata_d = rdata;
               state_d = StDone;
            end
         end
         StWrReq: begin
            if (wr_done) begin
`ifdef DATA_SRAM_POSTED_WR_EN
               state_d = StDone;
`else
               state_d = StWrResp;
`endif
            end
         end
         StWrResp: begin
            if (bvalid) begin
               state_d = StDone;
            end
         end
         // The request still presented here is the one just served.
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= StIdle;
         arvalid_q <= 1'b0;
         addr_q    <= 32'h0;
         wen_q     <= 4'h0;
         wdata_q   <= 32'h0;
         rdata_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         arvalid_q <= arvalid_d;
         addr_q    <= addr_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

endmodule
